// File: rtl/daq_fifo_rst_seq.sv
`timescale 1ns/1ps
// daq_fifo_rst_seq: reset sequencer for the DAQ FIFO bank.
// Walks the per-channel FIFO reset vector through settle (CLEAR), reset pulse
// (RESET), busy-release handshake with timeout (WAIT) and a PAUSE, then holds
// RUN with DONE high until a software re-run request arrives. Every output is
// registered from the next state, so it reflects the state entered on that edge.
module daq_fifo_rst_seq #(
    parameter int NCH       = 7,
    parameter int CNT_W     = 8,
    parameter int CLR_CYC   = 6,
    parameter int RST_CYC   = 11,
    parameter int PAUSE_CYC = 16,
    parameter int BUSY_TMO  = 255
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           req_i,
    input  logic [NCH-1:0] ch_en_i,
    input  logic [NCH-1:0] rst_busy_i,
    output logic [NCH-1:0] fifo_rst_o,
    output logic           done_o,
    output logic           busy_o,
    output logic           timeout_o,
    output logic [7:0]     seq_cnt_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RESET,
        S_WAIT,
        S_PAUSE,
        S_RUN
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [NCH-1:0]   mask_q, mask_d;
    logic             pending_q, pending_d;
    logic             timeout_q, timeout_d;
    logic [7:0]       seq_cnt_q, seq_cnt_d;
    logic [NCH-1:0]   fifo_rst_q, fifo_rst_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic             tmo_hit;
    logic             enter_clear;

    // State and output registers; everything returns to reset values while rst_i is high.
    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (rst_i) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            mask_q     <= '1;
            pending_q  <= 1'b0;
            timeout_q  <= 1'b0;
            seq_cnt_q  <= '0;
            fifo_rst_q <= '1;
            done_q     <= 1'b0;
            busy_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mask_q     <= mask_d;
            pending_q  <= pending_d;
            timeout_q  <= timeout_d;
            seq_cnt_q  <= seq_cnt_d;
            fifo_rst_q <= fifo_rst_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
        end
    end

    // Next-state logic: phase lengths, busy-release handshake and WAIT timeout.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can
        // leave it unassigned and infer a latch.
        state_d = state_q;
        tmo_hit = 1'b0;
        unique case (state_q)
            S_IDLE:  state_d = S_CLEAR;
            S_CLEAR: if (cnt_q == CNT_W'(CLR_CYC)) state_d = S_RESET;
            S_RESET: if (cnt_q == CNT_W'(RST_CYC)) state_d = S_WAIT;
            S_WAIT: begin
                if ((rst_busy_i & mask_q) == '0) begin
                    state_d = S_PAUSE;
                end else if (cnt_q == CNT_W'(BUSY_TMO)) begin
                    state_d = S_PAUSE;
                    tmo_hit = 1'b1;
                end
            end
            S_PAUSE: if (cnt_q == CNT_W'(PAUSE_CYC)) state_d = pending_q ? S_CLEAR : S_RUN;
            S_RUN:   if (req_i) state_d = S_CLEAR;
            default: state_d = S_IDLE;
        endcase
    end

    // Phase counter, latched mask, pending request, sticky timeout and run count.
    always_comb begin
        enter_clear = (state_d == S_CLEAR) && (state_q != S_CLEAR);

        if (state_d != state_q) begin
            cnt_d = CNT_W'(1);
        end else if (state_q inside {S_CLEAR, S_RESET, S_WAIT, S_PAUSE}) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end

        mask_d = enter_clear ? ch_en_i : mask_q;

        // Starting a sequence satisfies any outstanding request, so clearing wins.
        if (enter_clear) begin
            pending_d = 1'b0;
        end else if (req_i && (state_q != S_RUN)) begin
            pending_d = 1'b1;
        end else begin
            pending_d = pending_q;
        end

        if (enter_clear) begin
            timeout_d = 1'b0;
        end else if (tmo_hit) begin
            timeout_d = 1'b1;
        end else begin
            timeout_d = timeout_q;
        end

        seq_cnt_d = ((state_d == S_RUN) && (state_q != S_RUN)) ? seq_cnt_q + 8'd1 : seq_cnt_q;
    end

    // Output decode from the next state so outputs line up with the state entered.
    always_comb begin
        fifo_rst_d = '0;
        unique case (state_d)
            S_IDLE:  fifo_rst_d = '1;
            S_RESET: fifo_rst_d = mask_q;
            default: fifo_rst_d = '0;
        endcase
        done_d = (state_d == S_RUN);
        busy_d = (state_d != S_RUN);
    end

    assign fifo_rst_o = fifo_rst_q;
    assign done_o     = done_q;
    assign busy_o     = busy_q;
    assign timeout_o  = timeout_q;
    assign seq_cnt_o  = seq_cnt_q;

endmodule

// File: tb/tb_daq_fifo_rst_seq.sv
`timescale 1ns/1ps
// Testbench for daq_fifo_rst_seq: randomized masks, busy patterns and requests
// checked edge by edge against a timeline model derived from the phase lengths.
module tb_daq_fifo_rst_seq;

    localparam int NCH    = 7;
    localparam int CLR    = 6;
    localparam int RSTC   = 11;
    localparam int PAUSE  = 16;
    localparam int TMO    = 255;
    localparam int E_WAIT = CLR + RSTC + 1;   // relative edge on which WAIT is entered

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           req = 1'b0;
    logic [NCH-1:0] ch_en = '0;
    logic [NCH-1:0] rst_busy = '0;
    logic [NCH-1:0] fifo_rst;
    logic           done;
    logic           busy;
    logic           timeout;
    logic [7:0]     seq_cnt;

    int checks = 0;
    int errors = 0;
    int exp_seq = 0;
    bit exp_tmo = 1'b0;

    always #5 clk = ~clk;

    daq_fifo_rst_seq dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .req_i      (req),
        .ch_en_i    (ch_en),
        .rst_busy_i (rst_busy),
        .fifo_rst_o (fifo_rst),
        .done_o     (done),
        .busy_o     (busy),
        .timeout_o  (timeout),
        .seq_cnt_o  (seq_cnt)
    );

    // Busy flags seen at relative edge rel: stuck bits always, bvec for the first blen WAIT samples.
    function automatic logic [NCH-1:0] busy_at(input int rel, input logic [NCH-1:0] stuck,
                                               input logic [NCH-1:0] bvec, input int blen);
        return stuck | ((rel <= E_WAIT + blen) ? bvec : '0);
    endfunction

    // One sequence from its CLEAR-entry edge (rel 1) up to the edge before RUN would be entered.
    // Called between clock edges; the next rising edge is rel 1.
    task automatic run_seq(input logic [NCH-1:0] mask, input logic [NCH-1:0] stuck,
                           input logic [NCH-1:0] bvec, input int blen, input bit trig,
                           input int req_rel, input int stop_rel, output bit pend);
        int w;
        bit tmo;
        int e_run;
        int last;
        logic [NCH-1:0] exp_fifo;
        logic [10:0]    exp_stat;
        w = 0;
        for (int j = 1; j <= TMO; j++)
            if (w == 0 && (busy_at(E_WAIT + j, stuck, bvec, blen) & mask) == '0) w = j;
        tmo = (w == 0);
        if (tmo) w = TMO;
        e_run = E_WAIT + w + PAUSE;
        pend  = (req_rel >= 2) && (req_rel <= e_run - 1);
        last  = (stop_rel > 0 && stop_rel < e_run) ? stop_rel : e_run - 1;
        ch_en    = mask;
        req      = trig;
        rst_busy = busy_at(1, stuck, bvec, blen);
        for (int rel = 1; rel <= last; rel++) begin
            @(posedge clk);
            @(negedge clk);
            exp_fifo = (rel > CLR && rel <= CLR + RSTC) ? mask : '0;
            exp_stat = {1'b0, 1'b1, (tmo && rel >= E_WAIT + w), 8'(exp_seq)};
            checks++;
            if (fifo_rst !== exp_fifo) begin
                errors++;
                $display("FAIL seq_fifo_rst rel=%0d: got %h expected %h", rel, fifo_rst, exp_fifo);
            end
            checks++;
            if ({done, busy, timeout, seq_cnt} !== exp_stat) begin
                errors++;
                $display("FAIL seq_status rel=%0d: got done/busy/tmo/cnt=%h expected %h",
                         rel, {done, busy, timeout, seq_cnt}, exp_stat);
            end
            ch_en    = NCH'($urandom);
            req      = (rel + 1 == req_rel);
            rst_busy = busy_at(rel + 1, stuck, bvec, blen);
        end
        exp_tmo = tmo;
    endtask

    // RUN entry plus n-1 further RUN cycles; busy flags are noise here.
    task automatic check_run(input int n);
        exp_seq = (exp_seq + 1) % 256;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if ({fifo_rst, done, busy, timeout, seq_cnt} !== {7'h00, 1'b1, 1'b0, exp_tmo, 8'(exp_seq)}) begin
                errors++;
                $display("FAIL run_state cyc=%0d: got fifo=%h done=%b busy=%b tmo=%b cnt=%0d expected fifo=00 done=1 busy=0 tmo=%b cnt=%0d",
                         i, fifo_rst, done, busy, timeout, seq_cnt, exp_tmo, exp_seq);
            end
            rst_busy = NCH'($urandom);
        end
    endtask

    task automatic test_reset();
        req = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({fifo_rst, done, busy, timeout, seq_cnt} !== {7'h7F, 1'b0, 1'b1, 1'b0, 8'd0}) begin
            errors++;
            $display("FAIL reset_async: got fifo=%h done=%b busy=%b tmo=%b cnt=%0d expected 7f/0/1/0/0",
                     fifo_rst, done, busy, timeout, seq_cnt);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({fifo_rst, done, busy, timeout, seq_cnt} !== {7'h7F, 1'b0, 1'b1, 1'b0, 8'd0}) begin
            errors++;
            $display("FAIL reset_held: got fifo=%h done=%b busy=%b tmo=%b cnt=%0d expected 7f/0/1/0/0",
                     fifo_rst, done, busy, timeout, seq_cnt);
        end
        rst = 1'b0;
        exp_seq = 0;
        exp_tmo = 1'b0;
    endtask

    task automatic test_basic();
        bit pend;
        run_seq(7'h7F, '0, '0, 0, 1'b0, 0, 0, pend);
        check_run(4);
    endtask

    task automatic test_rerun();
        bit pend;
        run_seq(7'h7F, '0, '0, 0, 1'b1, 0, 0, pend);
        check_run(3);
    endtask

    task automatic test_mask_busy();
        bit pend;
        // bit0 busy for 19 WAIT samples (W = 20), bit1 stuck but masked off
        run_seq(7'h05, 7'h02, 7'h01, 19, 1'b1, 0, 0, pend);
        check_run(3);
    endtask

    task automatic test_timeout();
        bit pend;
        run_seq(7'h01, 7'h01, '0, 0, 1'b1, 0, 0, pend);
        check_run(3);
        // next CLEAR entry must drop TIMEOUT
        run_seq(7'h01, '0, '0, 0, 1'b1, 0, 0, pend);
        check_run(2);
    endtask

    task automatic test_mask_zero();
        bit pend;
        run_seq(7'h00, 7'h7F, '0, 0, 1'b1, 0, 0, pend);
        check_run(2);
    endtask

    task automatic test_pending();
        bit pend;
        test_reset();
        run_seq(7'h7F, '0, '0, 0, 1'b0, 20, 0, pend);
        run_seq(7'h7F, '0, '0, 0, 1'b0, 0, 0, pend);
        check_run(3);
    endtask

    task automatic test_rst_mid();
        bit pend;
        test_reset();
        run_seq(7'h3C, '0, '0, 0, 1'b0, 0, 10, pend);
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({fifo_rst, done, busy, timeout, seq_cnt} !== {7'h7F, 1'b0, 1'b1, 1'b0, 8'd0}) begin
            errors++;
            $display("FAIL rst_mid_async: got fifo=%h done=%b busy=%b tmo=%b cnt=%0d expected 7f/0/1/0/0",
                     fifo_rst, done, busy, timeout, seq_cnt);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_seq = 0;
        exp_tmo = 1'b0;
        run_seq(7'h3C, '0, '0, 0, 1'b0, 0, 0, pend);
        check_run(2);
    endtask

    task automatic test_random();
        bit pend;
        logic [NCH-1:0] mask, stuck, bvec;
        int blen, rr;
        for (int it = 0; it < 10; it++) begin
            mask  = NCH'($urandom);
            stuck = ($urandom_range(0, 3) == 0) ? NCH'($urandom) : '0;
            bvec  = NCH'($urandom);
            blen  = $urandom_range(0, 40);
            rr    = ($urandom_range(0, 2) == 0) ? $urandom_range(2, 34) : 0;
            run_seq(mask, stuck, bvec, blen, 1'b1, rr, 0, pend);
            while (pend) begin
                mask = NCH'($urandom);
                run_seq(mask, '0, NCH'($urandom), $urandom_range(0, 10), 1'b0, 0, 0, pend);
            end
            check_run($urandom_range(1, 4));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rerun();
        test_mask_busy();
        test_timeout();
        test_mask_zero();
        test_random();
        test_pending();
        test_rst_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

endmodule
